spi_regbank_bridge: RTL and testbench

- Parametrised SPI-slave to register-bank bridge. Lets the Raspberry Pi read and write a synchronous register or RAM bank (for example the Nios-shared data memory) over SPI.
- Adds a configurable address width, data width and read latency, plus auto-increment burst transfers, on top of a single-word SPI link.
- SPI pins are sampled in the clk_clk domain, so no second clock domain exists. clk_clk must be at least 8x spi_clk.

---
 rtl/spi_regbank_pkg.sv | 16 +
 rtl/spi_sync_edge.sv | 28 ++
 rtl/spi_regbank_bridge.sv | 208 ++++++++++++++++++++
 tb/tb_spi_regbank_bridge.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_regbank_pkg.sv
`timescale 1ns/1ps
// Shared types and header layout for the SPI register-bank bridge.
package spi_regbank_pkg;

  typedef enum logic [2:0] {IDLE, HDR, WR_DATA, RD_FETCH, RD_DATA} state_t;

  localparam int HDR_W       = 16;
  localparam int HDR_RW_BIT  = 15;
  localparam int HDR_INC_BIT = 14;
  localparam int WORD_CNT_W  = 16;

  function automatic logic [WORD_CNT_W-1:0] sat_inc(input logic [WORD_CNT_W-1:0] v);
    return (v == '1) ? v : v + WORD_CNT_W'(1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
`timescale 1ns/1ps
// N-stage synchroniser with rise/fall detect taken from its last two stages.
// Edge pulses are one clk wide and lag the pin by STAGES-1 cycles; no backpressure.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {STAGES{RST_VAL}};
    end else begin
      sync <= {sync[STAGES-2:0], din};
    end
  end

  assign rise = sync[STAGES-2] & ~sync[STAGES-1];
  assign fall = ~sync[STAGES-2] & sync[STAGES-1];

endmodule

// File: rtl/spi_regbank_bridge.sv
`timescale 1ns/1ps
// SPI mode-0 slave bridging 16-bit header frames to a synchronous register bank.
// mem_we within SYNC_STAGES+2 clk_clk cycles of the last data bit; the SPI master cannot be stalled.
module spi_regbank_bridge
  import spi_regbank_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 32,
  parameter int RD_LAT      = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  spi_clk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_re,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  frame_active,
  output logic                  frame_done,
  output logic [WORD_CNT_W-1:0] word_count
);

  localparam int RX_W  = (DATA_W > HDR_W) ? DATA_W : HDR_W;
  localparam int CNT_W = 7;

  state_t state, state_nxt;

  logic              clk_rise, clk_fall, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic              mosi_s;
  logic [RX_W-2:0]   rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] prefetch;
  logic [CNT_W-1:0]  bit_cnt;
  logic [RD_LAT-1:0] re_pipe;
  logic              inc;
  logic              word_done;
  logic              abort;
  logic              hdr_done;
  logic [ADDR_W-1:0] hdr_addr;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk  (clk_clk),
    .rst_n(reset_reset_n),
    .din  (spi_clk),
    .rise (clk_rise),
    .fall (clk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk  (clk_clk),
    .rst_n(reset_reset_n),
    .din  (spi_cs_n),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // MOSI is stable for half an SPI period around the rising edge, so the
  // oldest stage is a safe sample when the clock edge is seen.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      mosi_sync <= '0;
    end else begin
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
    end
  end
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign abort    = (state != IDLE) && cs_rise;
  assign hdr_done = (state == HDR) && clk_rise && (bit_cnt == CNT_W'(HDR_W-1));
  assign hdr_addr = ADDR_W'({rx_shift[HDR_W-2:0], mosi_s});

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (cs_fall) state_nxt = HDR;
      HDR:      if (hdr_done) state_nxt = rx_shift[HDR_RW_BIT-1] ? WR_DATA : RD_FETCH;
      RD_FETCH: if (re_pipe[RD_LAT-1]) state_nxt = RD_DATA;
      default:  state_nxt = state;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Tracks outstanding reads; cleared on abort so a pending prefetch is dropped.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      re_pipe <= '0;
    end else if (abort) begin
      re_pipe <= '0;
    end else begin
      re_pipe[0] <= mem_re;
      for (int i = 1; i < RD_LAT; i++) re_pipe[i] <= re_pipe[i-1];
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      spi_miso     <= 1'b0;
      mem_addr     <= '0;
      mem_re       <= 1'b0;
      mem_we       <= 1'b0;
      mem_wdata    <= '0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
      word_count   <= '0;
      rx_shift     <= '0;
      tx_shift     <= '0;
      prefetch     <= '0;
      bit_cnt      <= '0;
      inc          <= 1'b0;
      word_done    <= 1'b0;
    end else begin
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      frame_done <= 1'b0;
      if (abort) begin
        frame_active <= 1'b0;
        frame_done   <= 1'b1;
        spi_miso     <= 1'b0;
        word_done    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              frame_active <= 1'b1;
              bit_cnt      <= '0;
              word_count   <= '0;
              word_done    <= 1'b0;
              spi_miso     <= 1'b0;
            end
          end
          HDR: begin
            if (clk_rise) begin
              rx_shift <= {rx_shift[RX_W-3:0], mosi_s};
              if (hdr_done) begin
                bit_cnt  <= '0;
                mem_addr <= hdr_addr;
                inc      <= rx_shift[HDR_INC_BIT-1];
                mem_re   <= ~rx_shift[HDR_RW_BIT-1];
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          WR_DATA: begin
            // Address moves only after the write strobe has been seen by the bank.
            if (mem_we && inc) mem_addr <= mem_addr + ADDR_W'(1);
            if (clk_rise) begin
              rx_shift <= {rx_shift[RX_W-3:0], mosi_s};
              if (bit_cnt == CNT_W'(DATA_W-1)) begin
                bit_cnt    <= '0;
                mem_we     <= 1'b1;
                mem_wdata  <= {rx_shift[DATA_W-2:0], mosi_s};
                word_count <= sat_inc(word_count);
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          RD_FETCH: begin
            if (re_pipe[RD_LAT-1]) tx_shift <= mem_rdata;
          end
          RD_DATA: begin
            if (re_pipe[RD_LAT-1]) prefetch <= mem_rdata;
            if (clk_rise) begin
              if (bit_cnt == '0) begin
                mem_re <= 1'b1;
                if (inc) mem_addr <= mem_addr + ADDR_W'(1);
              end
              if (bit_cnt == CNT_W'(DATA_W-1)) begin
                bit_cnt    <= '0;
                word_done  <= 1'b1;
                word_count <= sat_inc(word_count);
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
            if (clk_fall) begin
              if (word_done) begin
                spi_miso  <= prefetch[DATA_W-1];
                tx_shift  <= {prefetch[DATA_W-2:0], 1'b0};
                word_done <= 1'b0;
              end else begin
                spi_miso <= tx_shift[DATA_W-1];
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_regbank_bridge.sv
`timescale 1ns/1ps
// Scoreboard bench for spi_regbank_bridge: SPI master tasks, a RD_LAT=2 bank model, per-scenario checks.
module tb_spi_regbank_bridge;

  localparam int AW = 7;
  localparam int DW = 32;
  localparam int RL = 2;
  localparam int SS = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk_clk = 1'b0;
  logic          reset_reset_n;
  logic          spi_clk, spi_cs_n, spi_mosi;
  logic          spi_miso;
  logic [AW-1:0] mem_addr;
  logic          mem_re, mem_we;
  logic [DW-1:0] mem_rdata, mem_wdata;
  logic          frame_active, frame_done;
  logic [15:0]   word_count;

  int checks = 0;
  int fails  = 0;

  wr_t           exp_wr_q[$];
  wr_t           obs_wr_q[$];
  logic [DW-1:0] exp_rd_q[$];

  int  done_count = 0;
  int  overlap_count = 0;
  int  max_we_lat = 0;
  time last_rise_t = 0;

  logic [DW-1:0] bank [2**AW];
  logic [DW-1:0] rd1, rd2;

  always #5 clk_clk = ~clk_clk;

  spi_regbank_bridge #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .SYNC_STAGES(SS)) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .spi_clk      (spi_clk),
    .spi_cs_n     (spi_cs_n),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .mem_addr     (mem_addr),
    .mem_re       (mem_re),
    .mem_rdata    (mem_rdata),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .frame_active (frame_active),
    .frame_done   (frame_done),
    .word_count   (word_count)
  );

  // Bank with two-cycle read latency.
  always @(posedge clk_clk) begin
    if (mem_we) bank[mem_addr] <= mem_wdata;
    rd1 <= bank[mem_addr];
    rd2 <= rd1;
  end
  assign mem_rdata = rd2;

  always @(posedge spi_clk) last_rise_t = $time;

  always @(negedge clk_clk) begin
    if (reset_reset_n === 1'b1) begin
      if (mem_we) begin
        obs_wr_q.push_back('{mem_addr, mem_wdata});
        if (int'(($time - last_rise_t) / 10) > max_we_lat) max_we_lat = int'(($time - last_rise_t) / 10);
      end
      if (mem_we && mem_re) overlap_count++;
      if (frame_done) done_count++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic spi_xfer(input logic [63:0] tx, input int n, output logic [63:0] rx);
    rx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_mosi = tx[i];
      #80;
      rx[i] = spi_miso;
      spi_clk = 1'b1;
      #80;
      spi_clk = 1'b0;
    end
  endtask

  task automatic frame_begin();
    spi_cs_n = 1'b0;
    #160;
  endtask

  task automatic frame_end();
    #80;
    spi_cs_n = 1'b1;
    #200;
  endtask

  task automatic test_reset();
    reset_reset_n = 1'b0;
    #25;
    checks++;
    if ({spi_miso, mem_addr, mem_re, mem_we, mem_wdata, frame_active, frame_done, word_count} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got miso=%b addr=%h re=%b we=%b wdata=%h act=%b done=%b wc=%h, expected all 0",
               spi_miso, mem_addr, mem_re, mem_we, mem_wdata, frame_active, frame_done, word_count);
    end
    reset_reset_n = 1'b1;
    #100;
    checks++;
    if (frame_active !== 1'b0 || done_count !== 0) begin
      fails++;
      $display("FAIL reset_idle: frame_active=%b done_count=%0d, expected 0 and 0", frame_active, done_count);
    end
  endtask

  task automatic test_single_write();
    logic [63:0] r;
    wr_t e, o;
    int d0 = done_count;
    exp_wr_q.push_back('{7'h05, 32'hDEADBEEF});
    frame_begin();
    spi_xfer(64'h8005, 16, r);
    spi_xfer(64'hDEADBEEF, 32, r);
    frame_end();
    checks++;
    if (obs_wr_q.size() != exp_wr_q.size()) begin
      fails++;
      $display("FAIL single_wr_count: got %0d writes, expected %0d", obs_wr_q.size(), exp_wr_q.size());
    end
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front();
      o = obs_wr_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL single_wr: got addr=%h data=%h, expected addr=%h data=%h", o.addr, o.data, e.addr, e.data);
      end
    end
    exp_wr_q.delete(); obs_wr_q.delete();
    checks++;
    if (word_count !== 16'd1) begin
      fails++;
      $display("FAIL single_wc: got %0d, expected 1", word_count);
    end
    checks++;
    if (done_count - d0 !== 1 || frame_active !== 1'b0) begin
      fails++;
      $display("FAIL single_done: got %0d pulses active=%b, expected 1 pulse active=0", done_count - d0, frame_active);
    end
  endtask

  task automatic test_burst_write();
    logic [63:0] r;
    wr_t e, o;
    exp_wr_q.push_back('{7'h7E, 32'd1});
    exp_wr_q.push_back('{7'h7F, 32'd2});
    exp_wr_q.push_back('{7'h00, 32'd3});
    frame_begin();
    spi_xfer(64'hC07E, 16, r);
    for (int w = 1; w <= 3; w++) spi_xfer(64'(w), 32, r);
    frame_end();
    checks++;
    if (obs_wr_q.size() != exp_wr_q.size()) begin
      fails++;
      $display("FAIL burst_wr_count: got %0d writes, expected %0d", obs_wr_q.size(), exp_wr_q.size());
    end
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front();
      o = obs_wr_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL burst_wr: got addr=%h data=%h, expected addr=%h data=%h", o.addr, o.data, e.addr, e.data);
      end
    end
    exp_wr_q.delete(); obs_wr_q.delete();
    checks++;
    if (word_count !== 16'd3) begin
      fails++;
      $display("FAIL burst_wc: got %0d, expected 3", word_count);
    end
  endtask

  task automatic test_burst_read();
    logic [63:0] r;
    logic [DW-1:0] e;
    bank[10] = 32'h11111111;
    bank[11] = 32'h22222222;
    bank[12] = 32'h33333333;
    exp_rd_q.push_back(32'h11111111);
    exp_rd_q.push_back(32'h22222222);
    frame_begin();
    spi_xfer(64'h400A, 16, r);
    checks++;
    if (r[15:0] !== 16'h0000) begin
      fails++;
      $display("FAIL rd_hdr_miso: got %h during header, expected 0000", r[15:0]);
    end
    for (int w = 0; w < 2; w++) begin
      spi_xfer(64'h0, 32, r);
      e = exp_rd_q.pop_front();
      checks++;
      if (r[DW-1:0] !== e) begin
        fails++;
        $display("FAIL burst_rd_word%0d: got %h, expected %h", w, r[DW-1:0], e);
      end
    end
    frame_end();
    checks++;
    if (word_count !== 16'd2) begin
      fails++;
      $display("FAIL burst_rd_wc: got %0d, expected 2", word_count);
    end
  endtask

  task automatic test_noinc_read();
    logic [63:0] r;
    logic [DW-1:0] e;
    bank[3] = 32'hA5C30F96;
    bank[4] = 32'h5A5A5A5A;
    exp_rd_q.push_back(32'hA5C30F96);
    exp_rd_q.push_back(32'hA5C30F96);
    frame_begin();
    spi_xfer(64'h0003, 16, r);
    for (int w = 0; w < 2; w++) begin
      spi_xfer(64'h0, 32, r);
      e = exp_rd_q.pop_front();
      checks++;
      if (r[DW-1:0] !== e) begin
        fails++;
        $display("FAIL noinc_rd_word%0d: got %h, expected %h", w, r[DW-1:0], e);
      end
    end
    frame_end();
    checks++;
    if (mem_addr !== 7'd3) begin
      fails++;
      $display("FAIL noinc_addr: got %h, expected 03", mem_addr);
    end
  endtask

  task automatic test_abort();
    logic [63:0] r;
    int d0 = done_count;
    frame_begin();
    spi_xfer(64'h8001, 16, r);
    spi_xfer(64'hFFFFF, 20, r);
    frame_end();
    checks++;
    if (obs_wr_q.size() != 0) begin
      fails++;
      $display("FAIL abort_no_we: got %0d writes, expected 0", obs_wr_q.size());
    end
    obs_wr_q.delete();
    checks++;
    if (word_count !== 16'd0) begin
      fails++;
      $display("FAIL abort_wc: got %0d, expected 0", word_count);
    end
    checks++;
    if (done_count - d0 !== 1 || frame_active !== 1'b0) begin
      fails++;
      $display("FAIL abort_done: got %0d pulses active=%b, expected 1 pulse active=0", done_count - d0, frame_active);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [63:0] r;
    wr_t e, o;
    int d0 = done_count;
    frame_begin();
    spi_xfer(64'h0003, 16, r);
    spi_xfer(64'h0, 10, r);
    spi_mosi = 1'b0;
    #40;
    reset_reset_n = 1'b0;
    #1;
    checks++;
    if ({spi_miso, mem_addr, mem_re, mem_we, mem_wdata, frame_active, frame_done, word_count} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: got miso=%b addr=%h re=%b we=%b wdata=%h act=%b done=%b wc=%h, expected all 0",
               spi_miso, mem_addr, mem_re, mem_we, mem_wdata, frame_active, frame_done, word_count);
    end
    #19;
    spi_cs_n = 1'b1;
    #40;
    reset_reset_n = 1'b1;
    #100;
    exp_wr_q.push_back('{7'h10, 32'h0BADF00D});
    frame_begin();
    spi_xfer(64'h8010, 16, r);
    spi_xfer(64'h0BADF00D, 32, r);
    frame_end();
    checks++;
    if (obs_wr_q.size() != exp_wr_q.size()) begin
      fails++;
      $display("FAIL midreset_wr_count: got %0d writes, expected %0d", obs_wr_q.size(), exp_wr_q.size());
    end
    while (exp_wr_q.size() > 0 && obs_wr_q.size() > 0) begin
      e = exp_wr_q.pop_front();
      o = obs_wr_q.pop_front();
      checks++;
      if (o !== e) begin
        fails++;
        $display("FAIL midreset_wr: got addr=%h data=%h, expected addr=%h data=%h", o.addr, o.data, e.addr, e.data);
      end
    end
    exp_wr_q.delete(); obs_wr_q.delete();
    checks++;
    if (word_count !== 16'd1 || done_count - d0 !== 1) begin
      fails++;
      $display("FAIL midreset_frame: got wc=%0d pulses=%0d, expected wc=1 pulses=1", word_count, done_count - d0);
    end
  endtask

  task automatic test_strobes();
    checks++;
    if (overlap_count !== 0) begin
      fails++;
      $display("FAIL strobe_overlap: got %0d cycles with mem_re and mem_we, expected 0", overlap_count);
    end
    checks++;
    if (max_we_lat > SS + 2) begin
      fails++;
      $display("FAIL we_latency: got %0d cycles, expected at most %0d", max_we_lat, SS + 2);
    end
  endtask

  initial begin
    reset_reset_n = 1'b1;
    spi_clk  = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    test_reset();
    test_single_write();
    test_burst_write();
    test_burst_read();
    test_noinc_read();
    test_abort();
    test_reset_mid_read();
    test_strobes();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
